// File: rtl/seq_squarer_pkg.sv
// seq_squarer_pkg: shared state type, default parameters and saturating add
package seq_squarer_pkg;
  typedef enum logic {IDLE, CALC} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int ACC_PAD = 4;
  localparam int SAT_W = 64;
  typedef struct packed {
    logic ovf;
    logic [SAT_W-1:0] sum;
  } sat_t;
  function automatic sat_t sat_add(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b, input int w);
    logic [SAT_W:0] s;
    logic [SAT_W:0] lim;
    s = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_W{1'b0}}, 1'b1} << w) - (SAT_W+1)'(1);
    sat_add = s > lim ? sat_t'(lim | {1'b1, {SAT_W{1'b0}}}) : sat_t'(s);
  endfunction
endpackage

// File: rtl/sq_accum.sv
// sq_accum: saturating sum-of-squares accumulator with clear priority and sticky overflow
module sq_accum
  import seq_squarer_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_en,
  input  logic [ACC_W-1:0] add_val,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);
  sat_t r;
  always_comb r = sat_add(SAT_W'(acc), SAT_W'(add_val), ACC_W);
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= ACC_W'(r.sum);
      ovf <= ovf | r.ovf;
    end
  end
endmodule

// File: rtl/seq_squarer.sv
// seq_squarer: shift-add sequential squarer with start/busy/done handshake and accumulator
module seq_squarer
  import seq_squarer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = 2*WIDTH+ACC_PAD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] sq,
  output logic [ACC_W-1:0]   acc,
  output logic               ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic accq;
  logic [2*WIDTH-1:0] p, p_next;
  logic [CW-1:0] cnt;
  logic last, fin;
  assign p_next = p + (b_q[cnt] ? {{WIDTH{1'b0}}, a_q} << cnt : '0);
  assign last = cnt == CW'(WIDTH-1);
  assign fin = state == CALC && last;
  assign busy = state == CALC;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (start ? CALC : IDLE) : (last ? IDLE : CALC);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      accq <= 1'b0;
      p <= '0;
      cnt <= '0;
      sq <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE && start) begin
        a_q <= din;
        b_q <= din;
        accq <= acc_en;
        p <= '0;
        cnt <= '0;
      end else if (state == CALC && !last) begin
        p <= p_next;
        cnt <= cnt + CW'(1);
      end else if (fin) begin
        sq <= p_next;
      end
    end
  end
  sq_accum #(.ACC_W(ACC_W)) u_acc (
    .clk(clk),
    .rst(rst),
    .add_en(fin && accq),
    .add_val(ACC_W'(p_next)),
    .acc_clr(acc_clr),
    .acc(acc),
    .ovf(ovf)
  );
endmodule

// File: tb/tb_seq_squarer.sv
// tb_seq_squarer: randomized scoreboard bench for seq_squarer against an arithmetic model
module tb_seq_squarer;
  localparam int W = 4;
  localparam int AW = 2*W+4;
  localparam int MAXA = (1 << AW) - 1;
  typedef struct {
    int sq;
    int acc;
    bit ovf;
    int t0;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic acc_en = 1'b0;
  logic acc_clr = 1'b0;
  logic [W-1:0] din = '0;
  logic busy, done, ovf;
  logic [2*W-1:0] sq;
  logic [AW-1:0] acc;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bcnt = 0;
  int acc_m = 0;
  bit ovf_m = 1'b0;
  seq_squarer #(.WIDTH(W), .ACC_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .din(din),
    .acc_en(acc_en),
    .acc_clr(acc_clr),
    .busy(busy),
    .done(done),
    .sq(sq),
    .acc(acc),
    .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) bcnt = 0;
    else if (busy) bcnt++;
    if (done && !rst) begin
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        check("sq", int'(sq), e.sq);
        check("acc", int'(acc), e.acc);
        check("ovf", int'(ovf), int'(e.ovf));
        check("latency", cyc - e.t0, W);
        check("busy_len", bcnt, W);
      end
      bcnt = 0;
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", 1, 0);
  endtask
  task automatic issue(input int d, input bit en, input bit clr);
    exp_t e;
    int s;
    wait_idle();
    din = W'(d);
    acc_en = en;
    start = 1'b1;
    if (clr) begin
      acc_m = 0;
      ovf_m = 1'b0;
    end else if (en) begin
      s = acc_m + d*d;
      if (s > MAXA) begin
        acc_m = MAXA;
        ovf_m = 1'b1;
      end else acc_m = s;
    end
    e = '{d*d, acc_m, ovf_m, cyc+1};
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    din = W'($urandom);
    acc_en = 1'($urandom);
    if (clr) begin
      repeat (W-1) @(negedge clk);
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
    end
  endtask
  task automatic clear();
    wait_idle();
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    acc_m = 0;
    ovf_m = 1'b0;
    check("clr_acc", int'(acc), 0);
    check("clr_ovf", int'(ovf), 0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sq", int'(sq), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 16; d++) issue(d, 1'($urandom), 1'b0);
    clear();
    issue(3, 1'b1, 1'b0);
    issue(5, 1'b1, 1'b0);
    issue(15, 1'b1, 1'b0);
    issue(7, 1'b0, 1'b0);
    clear();
    for (int i = 0; i < 20; i++) issue(15, 1'b1, 1'b0);
    issue(0, 1'b1, 1'b0);
    issue(6, 1'b0, 1'b0);
    clear();
    issue(9, 1'b1, 1'b0);
    @(negedge clk);
    din = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(2, 1'b1, 1'b0);
    wait_idle();
    @(negedge clk);
    din = 13;
    acc_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_m = 0;
    ovf_m = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_sq", int'(sq), 0);
    check("midrst_acc", int'(acc), 0);
    repeat (W+2) @(negedge clk);
    issue(13, 1'b1, 1'b0);
    clear();
    issue(5, 1'b1, 1'b0);
    issue(5, 1'b1, 1'b0);
    issue(4, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
